atm_txn_ctrl: RTL and testbench

Transaction sequencer directly upstream of the balance register. It authenticates a card holder by PIN, accepts a deposit or withdrawal request with a 7-bit amount, and issues exactly one single-cycle `dep_en`/`with_en` strobe with a stable `price` to the balance register. It predicts the outcome from the current `balance`, reports success or failure, and enforces a session timeout and a PIN-retry lockout.

---
 rtl/atm_txn_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_txn_ctrl.sv
// ATM transaction sequencer: PIN authentication, deposit/withdraw request,
// outcome prediction against the current balance, session timeout and lockout.
module atm_txn_ctrl #(
    parameter logic [3:0] PIN_CODE    = 4'd5,
    parameter int         MAX_TRIES   = 3,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       card_in,
    input  logic [3:0] pin_in,
    input  logic       pin_enter,
    input  logic       dep_req,
    input  logic       with_req,
    input  logic [6:0] amount_in,
    input  logic       confirm,
    input  logic       cancel,
    input  logic [7:0] balance,
    output logic       dep_en,
    output logic       with_en,
    output logic [6:0] price,
    output logic       txn_ok,
    output logic       txn_fail,
    output logic       locked,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PIN    = 3'd1,
        S_MENU   = 3'd2,
        S_AMOUNT = 3'd3,
        S_EXEC   = 3'd4,
        S_DONE   = 3'd5,
        S_LOCK   = 3'd6
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      tries_reg, tries_next;
    logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [6:0]      price_reg, price_next;
    logic            op_wdr_reg, op_wdr_next;
    logic            dep_en_reg, dep_en_next;
    logic            with_en_reg, with_en_next;
    logic            txn_ok_reg, txn_ok_next;
    logic            txn_fail_reg, txn_fail_next;
    logic            locked_reg, locked_next;

    logic            any_strobe;
    logic            in_session;
    logic            tmo_hit;
    logic [2:0]      tries_inc;
    logic [8:0]      dep_sum;
    logic            dep_legal;
    logic            wdr_legal;

    assign any_strobe = pin_enter | dep_req | with_req | confirm | cancel;
    assign in_session = (state_reg == S_PIN) || (state_reg == S_MENU) ||
                        (state_reg == S_AMOUNT) || (state_reg == S_DONE);
    // Fires on the TIMEOUT_CYC-th consecutive strobe-free cycle in a state.
    assign tmo_hit    = in_session && !any_strobe &&
                        (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));
    assign tries_inc  = tries_reg + 3'd1;
    assign dep_sum    = {1'b0, balance} + {2'b00, price_reg};
    assign dep_legal  = (price_reg != 7'd0) && (dep_sum <= 9'd255);
    assign wdr_legal  = ({1'b0, price_reg} < balance);

    always_comb begin
        state_next    = state_reg;
        tries_next    = tries_reg;
        price_next    = price_reg;
        op_wdr_next   = op_wdr_reg;
        dep_en_next   = 1'b0;
        with_en_next  = 1'b0;
        txn_ok_next   = 1'b0;
        txn_fail_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (card_in) begin
                    state_next = S_PIN;
                    tries_next = 3'd0;
                end
            end
            S_PIN: begin
                if (!card_in)        state_next = S_IDLE;
                else if (cancel)     state_next = S_DONE;
                else if (tmo_hit)    state_next = S_IDLE;
                else if (pin_enter) begin
                    if (pin_in == PIN_CODE) begin
                        state_next = S_MENU;
                    end else begin
                        tries_next = tries_inc;
                        if (tries_inc == 3'(MAX_TRIES))
                            state_next = S_LOCK;
                    end
                end
            end
            S_MENU: begin
                if (!card_in)        state_next = S_IDLE;
                else if (cancel)     state_next = S_DONE;
                else if (tmo_hit)    state_next = S_IDLE;
                else if (dep_req && !with_req) begin
                    state_next  = S_AMOUNT;
                    op_wdr_next = 1'b0;
                end else if (with_req && !dep_req) begin
                    state_next  = S_AMOUNT;
                    op_wdr_next = 1'b1;
                end
            end
            S_AMOUNT: begin
                if (!card_in)        state_next = S_IDLE;
                else if (cancel)     state_next = S_DONE;
                else if (tmo_hit) begin
                    state_next    = S_IDLE;
                    txn_fail_next = 1'b1;
                end else if (confirm) begin
                    price_next = amount_in;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                // Always completes; a removed card only redirects the exit.
                if (op_wdr_reg) begin
                    with_en_next  = wdr_legal;
                    txn_ok_next   = wdr_legal;
                    txn_fail_next = !wdr_legal;
                end else begin
                    dep_en_next   = dep_legal;
                    txn_ok_next   = dep_legal;
                    txn_fail_next = !dep_legal;
                end
                state_next = card_in ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!card_in)        state_next = S_IDLE;
                else if (tmo_hit)    state_next = S_IDLE;
                else if (confirm)    state_next = S_MENU;
            end
            S_LOCK: state_next = S_LOCK;
            default: state_next = S_IDLE;
        endcase

        if (in_session && !any_strobe && (state_next == state_reg))
            tmo_cnt_next = tmo_cnt_reg + TW'(1);
        else
            tmo_cnt_next = '0;

        locked_next = (state_next == S_LOCK);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg    <= S_IDLE;
            tries_reg    <= 3'd0;
            tmo_cnt_reg  <= '0;
            price_reg    <= 7'd0;
            op_wdr_reg   <= 1'b0;
            dep_en_reg   <= 1'b0;
            with_en_reg  <= 1'b0;
            txn_ok_reg   <= 1'b0;
            txn_fail_reg <= 1'b0;
            locked_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tries_reg    <= tries_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            price_reg    <= price_next;
            op_wdr_reg   <= op_wdr_next;
            dep_en_reg   <= dep_en_next;
            with_en_reg  <= with_en_next;
            txn_ok_reg   <= txn_ok_next;
            txn_fail_reg <= txn_fail_next;
            locked_reg   <= locked_next;
        end
    end

    assign dep_en   = dep_en_reg;
    assign with_en  = with_en_reg;
    assign price    = price_reg;
    assign txn_ok   = txn_ok_reg;
    assign txn_fail = txn_fail_reg;
    assign locked   = locked_reg;
    assign state_o  = state_reg;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Scoreboard bench for atm_txn_ctrl: stimulus pushes expected result pulses,
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_atm_txn_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       card_in;
    logic [3:0] pin_in;
    logic       pin_enter;
    logic       dep_req;
    logic       with_req;
    logic [6:0] amount_in;
    logic       confirm;
    logic       cancel;
    logic [7:0] balance;
    logic       dep_en;
    logic       with_en;
    logic [6:0] price;
    logic       txn_ok;
    logic       txn_fail;
    logic       locked;
    logic [2:0] state_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       d;
        logic       w;
        logic       ok;
        logic       fail;
        logic       chkp;
        logic [6:0] price;
    } evt_t;

    evt_t exp_q[$];

    atm_txn_ctrl #(
        .PIN_CODE   (4'd5),
        .MAX_TRIES  (3),
        .TIMEOUT_CYC(10)
    ) dut (
        .clk      (clk),
        .res      (res),
        .card_in  (card_in),
        .pin_in   (pin_in),
        .pin_enter(pin_enter),
        .dep_req  (dep_req),
        .with_req (with_req),
        .amount_in(amount_in),
        .confirm  (confirm),
        .cancel   (cancel),
        .balance  (balance),
        .dep_en   (dep_en),
        .with_en  (with_en),
        .price    (price),
        .txn_ok   (txn_ok),
        .txn_fail (txn_fail),
        .locked   (locked),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: one pop per cycle with any result/enable pulse.
    always @(negedge clk) begin
        if (dep_en || with_en || txn_ok || txn_fail) begin
            evt_t e;
            tests++;
            $display("[TB] txn dep_en=%0b with_en=%0b ok=%0b fail=%0b price=%0d state=%0d",
                     dep_en, with_en, txn_ok, txn_fail, price, state_o);
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got d=%0b w=%0b ok=%0b fail=%0b required none",
                         dep_en, with_en, txn_ok, txn_fail);
            end else begin
                e = exp_q.pop_front();
                if ({dep_en, with_en, txn_ok, txn_fail} !== {e.d, e.w, e.ok, e.fail} ||
                    (e.chkp && price !== e.price)) begin
                    fails++;
                    $display("FAIL pulse: got d=%0b w=%0b ok=%0b fail=%0b price=%0d required d=%0b w=%0b ok=%0b fail=%0b price=%0d",
                             dep_en, with_en, txn_ok, txn_fail, price,
                             e.d, e.w, e.ok, e.fail, e.price);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_evt(input logic d, input logic w, input logic ok,
                              input logic f, input logic chkp, input logic [6:0] p);
        evt_t e;
        e.d = d; e.w = w; e.ok = ok; e.fail = f; e.chkp = chkp; e.price = p;
        exp_q.push_back(e);
    endtask

    task automatic do_pin(input logic [3:0] v);
        pin_in = v; pin_enter = 1'b1; tick(); pin_enter = 1'b0;
    endtask

    task automatic do_req(input logic is_dep);
        dep_req = is_dep; with_req = !is_dep; tick();
        dep_req = 1'b0; with_req = 1'b0;
    endtask

    task automatic do_confirm(input logic [6:0] a);
        amount_in = a; confirm = 1'b1; tick(); confirm = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    // Starts in MENU, ends back in MENU.
    task automatic run_txn(input string name, input logic is_dep, input logic [6:0] amt,
                           input logic [7:0] bal, input logic legal);
        balance = bal;
        do_req(is_dep);
        chk({name, "_amount_state"}, 32'(state_o), 32'd3);
        expect_evt(is_dep & legal, !is_dep & legal, legal, !legal, 1'b1, amt);
        do_confirm(amt);
        chk({name, "_exec_state"}, 32'(state_o), 32'd4);
        chk({name, "_price_n1"}, 32'(price), 32'(amt));
        tick();
        chk({name, "_done_state"}, 32'(state_o), 32'd5);
        tick();
        chk({name, "_price_hold"}, 32'(price), 32'(amt));
        do_confirm(7'd0);
        chk({name, "_back_menu"}, 32'(state_o), 32'd2);
    endtask

    initial begin
        res = 1'b1; card_in = 1'b0; pin_in = 4'd0; pin_enter = 1'b0;
        dep_req = 1'b0; with_req = 1'b0; amount_in = 7'd0; confirm = 1'b0;
        cancel = 1'b0; balance = 8'd0;
        repeat (3) tick();
        res = 1'b0;
        tick();
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_outs", 32'({dep_en, with_en, txn_ok, txn_fail, locked}), 32'd0);
        chk("reset_price", 32'(price), 32'd0);

        // Authenticate and run deposit/withdraw boundary cases
        card_in = 1'b1; tick();
        chk("card_pin_state", 32'(state_o), 32'd1);
        do_pin(4'd5);
        chk("pin_ok_menu", 32'(state_o), 32'd2);
        run_txn("dep100", 1'b1, 7'd100, 8'd0, 1'b1);
        run_txn("dep60", 1'b1, 7'd60, 8'd200, 1'b0);
        run_txn("dep55", 1'b1, 7'd55, 8'd200, 1'b1);
        run_txn("dep0", 1'b1, 7'd0, 8'd200, 1'b0);
        run_txn("wdr40", 1'b0, 7'd40, 8'd40, 1'b0);
        run_txn("wdr39", 1'b0, 7'd39, 8'd40, 1'b1);

        dep_req = 1'b1; with_req = 1'b1; tick(); dep_req = 1'b0; with_req = 1'b0;
        chk("both_req_menu", 32'(state_o), 32'd2);

        // Cancel in MENU goes to DONE silently
        do_cancel();
        chk("cancel_done", 32'(state_o), 32'd5);
        repeat (2) tick();
        chk("cancel_stays_done", 32'(state_o), 32'd5);
        do_confirm(7'd0);
        chk("done_to_menu", 32'(state_o), 32'd2);

        // Timeout in AMOUNT after 10 strobe-free cycles
        do_req(1'b1);
        chk("tmo_amount", 32'(state_o), 32'd3);
        expect_evt(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        repeat (9) tick();
        chk("tmo_still_amount", 32'(state_o), 32'd3);
        tick();
        chk("tmo_idle", 32'(state_o), 32'd0);
        tick();
        chk("tmo_reenter_pin", 32'(state_o), 32'd1);

        // Card pulled during EXEC: enable still issued once, then IDLE
        do_pin(4'd5);
        balance = 8'd10;
        do_req(1'b1);
        expect_evt(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'd20);
        do_confirm(7'd20);
        chk("pull_exec_state", 32'(state_o), 32'd4);
        card_in = 1'b0;
        tick();
        chk("pull_idle", 32'(state_o), 32'd0);
        tick();
        chk("pull_stay_idle", 32'(state_o), 32'd0);

        // Reset during EXEC drops the pending enable
        card_in = 1'b1; tick();
        do_pin(4'd5);
        do_req(1'b0);
        balance = 8'd100;
        do_confirm(7'd30);
        chk("res_exec_state", 32'(state_o), 32'd4);
        res = 1'b1; tick(); res = 1'b0;
        chk("res_exec_outs", 32'({dep_en, with_en, txn_ok, txn_fail, locked}), 32'd0);
        chk("res_exec_price", 32'(price), 32'd0);
        chk("res_exec_idle", 32'(state_o), 32'd0);
        card_in = 1'b0;
        repeat (2) tick();

        // Lockout after three wrong PINs
        card_in = 1'b1; tick();
        do_pin(4'd3);
        chk("lock_try1", 32'(state_o), 32'd1);
        do_pin(4'd3);
        chk("lock_try2", 32'(state_o), 32'd1);
        do_pin(4'd3);
        chk("lock_state", 32'(state_o), 32'd6);
        chk("lock_flag", 32'(locked), 32'd1);
        card_in = 1'b0; tick();
        card_in = 1'b1; tick();
        do_pin(4'd5);
        do_req(1'b1);
        do_confirm(7'd5);
        do_cancel();
        repeat (12) tick();
        chk("lock_hold_state", 32'(state_o), 32'd6);
        chk("lock_hold_flag", 32'(locked), 32'd1);
        card_in = 1'b0;
        res = 1'b1; tick(); res = 1'b0;
        chk("unlock_state", 32'(state_o), 32'd0);
        chk("unlock_flag", 32'(locked), 32'd0);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
